// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : Multi-cycle RISC-V style control sequencer (FETCH/DECODE/EXEC/
//            MEM/WB/TRAP). Optional retired-instruction counter: MCSEQ_INSTRET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int COUNT_W    = 32,
    parameter int WAIT_LIMIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               branch_cond,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         pc_sel,
    output logic               alu_src_a,
    output logic               alu_src_b,
    output logic [1:0]         wb_sel,
    output logic [2:0]         state,
    output logic               retire,
    output logic               illegal,
    output logic               bus_err,
    output logic [COUNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R      = 4'd0,
        C_IMM    = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_JAL    = 4'd5,
        C_JALR   = 4'd6,
        C_LUI    = 4'd7,
        C_AUIPC  = 4'd8,
        C_BAD    = 4'd9
    } cls_t;

    state_t     r_state;
    state_t     w_next;
    cls_t       r_cls;
    cls_t       w_dec_cls;
    logic       r_illegal;
    logic       r_bus_err;
    logic       w_timeout;
    logic       w_set_illegal;
    logic       w_set_bus_err;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_addr_sel;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_retire;
    logic [1:0] w_pc_sel;
    logic [1:0] w_wb_sel;
    logic       w_cls_a;
    logic       w_cls_b;
    logic [1:0] w_cls_wb;
    logic       w_cls_jump;
    logic       w_src_valid;

    always_comb begin
        w_dec_cls = C_BAD;
        case (opcode)
            7'b0110011: w_dec_cls = C_R;
            7'b0010011: w_dec_cls = C_IMM;
            7'b0000011: w_dec_cls = C_LOAD;
            7'b0100011: w_dec_cls = C_STORE;
            7'b1100011: w_dec_cls = C_BRANCH;
            7'b1101111: w_dec_cls = C_JAL;
            7'b1100111: w_dec_cls = C_JALR;
            7'b0110111: w_dec_cls = C_LUI;
            7'b0010111: w_dec_cls = C_AUIPC;
            default:    w_dec_cls = C_BAD;
        endcase
    end

    // Datapath controls come from the class latched in DECODE so they hold through MEM/WB.
    always_comb begin
        w_cls_a    = 1'b0;
        w_cls_b    = 1'b0;
        w_cls_wb   = 2'd1;
        w_cls_jump = 1'b0;
        case (r_cls)
            C_IMM, C_STORE: w_cls_b = 1'b1;
            C_LOAD: begin
                w_cls_b  = 1'b1;
                w_cls_wb = 2'd3;
            end
            C_JALR: begin
                w_cls_b    = 1'b1;
                w_cls_wb   = 2'd2;
                w_cls_jump = 1'b1;
            end
            C_JAL: begin
                w_cls_a    = 1'b1;
                w_cls_b    = 1'b1;
                w_cls_wb   = 2'd2;
                w_cls_jump = 1'b1;
            end
            C_AUIPC: begin
                w_cls_a = 1'b1;
                w_cls_b = 1'b1;
            end
            C_LUI: begin
                w_cls_b  = 1'b1;
                w_cls_wb = 2'd0;
            end
            default: ;
        endcase
    end

    generate
        if (WAIT_LIMIT > 0) begin : g_wait
            localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
            logic [WAIT_W-1:0] r_wait;
            logic              w_waiting;

            assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
            // The limit-th idle cycle traps; a ready in that same cycle is never a timeout.
            assign w_timeout = w_waiting && (r_wait == WAIT_W'(WAIT_LIMIT - 1));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_wait <= '0;
                end else if (w_waiting) begin
                    r_wait <= r_wait + 1'b1;
                end else begin
                    r_wait <= '0;
                end
            end
        end else begin : g_no_wait
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cls     <= C_R;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_dec_cls;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_addr_sel    = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_retire      = 1'b0;
        w_pc_sel      = 2'd0;
        w_wb_sel      = 2'd0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next        = S_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_dec_cls == C_BAD) begin
                    w_next        = S_TRAP;
                    w_set_illegal = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cls == C_BRANCH) begin
                    w_pc_write = 1'b1;
                    w_pc_sel   = branch_cond ? 2'd2 : 2'd0;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else if ((r_cls == C_LOAD) || (r_cls == C_STORE)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_cls == C_STORE);
                if (mem_ready) begin
                    if (r_cls == C_STORE) begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next        = S_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_retire    = 1'b1;
                w_wb_sel    = w_cls_wb;
                w_pc_sel    = w_cls_jump ? 2'd1 : 2'd0;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    assign w_src_valid = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    // Strobes are suppressed combinationally in any cycle where reset is held low.
    assign mem_req   = reset & w_mem_req;
    assign mem_we    = reset & w_mem_we;
    assign ir_write  = reset & w_ir_write;
    assign pc_write  = reset & w_pc_write;
    assign reg_write = reset & w_reg_write;
    assign retire    = reset & w_retire;
    assign addr_sel  = w_addr_sel;
    assign pc_sel    = w_pc_sel;
    assign wb_sel    = w_wb_sel;
    assign alu_src_a = w_src_valid & w_cls_a;
    assign alu_src_b = w_src_valid & w_cls_b;
    assign state     = r_state;
    assign illegal   = r_illegal;
    assign bus_err   = r_bus_err;

`ifdef MCSEQ_INSTRET_EN
    logic [COUNT_W-1:0] r_instret;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Vector table, directed corner sequences and random stimulus
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int COUNT_W    = 4;
    localparam int WAIT_LIMIT = 4;
`ifdef MCSEQ_INSTRET_EN
    localparam bit INSTRET_EN = 1'b1;
`else
    localparam bit INSTRET_EN = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic [6:0]         opcode;
    logic               branch_cond;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               addr_sel;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    logic [1:0]         pc_sel;
    logic               alu_src_a;
    logic               alu_src_b;
    logic [1:0]         wb_sel;
    logic [2:0]         state;
    logic               retire;
    logic               illegal;
    logic               bus_err;
    logic [COUNT_W-1:0] instret;

    multicycle_sequencer #(
        .COUNT_W    (COUNT_W),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .branch_cond (branch_cond),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .pc_sel      (pc_sel),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .wb_sel      (wb_sel),
        .state       (state),
        .retire      (retire),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .instret     (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // str = {mem_req, mem_we, ir_write, pc_write, reg_write, retire}; flg = {illegal, bus_err}
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        bc;
        logic        mr;
        logic [2:0]  st;
        logic [5:0]  str;
        logic [1:0]  flg;
        logic        asel;
        logic [1:0]  psel;
        logic [1:0]  wsel;
        logic [1:0]  ab;
        int unsigned ic;
    } rec_t;

    // path: 0 = branch, 1 = store, 2 = load, 3 = ALU/jump/upper-immediate
    typedef struct {
        logic [6:0] op;
        int         path;
        logic [1:0] ab;
        logic [1:0] wsel;
        logic [1:0] psel;
    } kind_t;

    kind_t       kinds [9];
    rec_t        tbl [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  cur_op;

    int          m_plan [$];
    int          m_kind;
    int          m_wait;
    bit          m_ill;
    bit          m_bus;
    int unsigned m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rec(input string tag, input rec_t e);
        logic [5:0]  a_str;
        int unsigned exp_ic;
        a_str  = {mem_req, mem_we, ir_write, pc_write, reg_write, retire};
        exp_ic = INSTRET_EN ? (e.ic % (32'd1 << COUNT_W)) : 32'd0;
        chk({tag, " state"},   32'(state), 32'(e.st));
        chk({tag, " strobes"}, 32'(a_str), 32'(e.str));
        chk({tag, " flags"},   32'({illegal, bus_err}), 32'(e.flg));
        chk({tag, " instret"}, 32'(instret), exp_ic);
        if (e.str[5]) chk({tag, " addr_sel"}, 32'(addr_sel), 32'(e.asel));
        if (e.str[2]) chk({tag, " pc_sel"}, 32'(pc_sel), 32'(e.psel));
        if (e.str[1]) chk({tag, " wb_sel"}, 32'(wb_sel), 32'(e.wsel));
        if (e.rst && (e.st inside {3'd2, 3'd3, 3'd4}))
            chk({tag, " alu_src"}, 32'({alu_src_a, alu_src_b}), 32'(e.ab));
    endtask

    function automatic rec_t mk(logic rst, logic [6:0] op, logic bc, logic mr, logic [2:0] st,
                                logic [5:0] str, logic [1:0] flg, logic asel, logic [1:0] psel,
                                logic [1:0] wsel, logic [1:0] ab, int unsigned ic);
        rec_t r;
        r.rst = rst; r.op = op; r.bc = bc; r.mr = mr; r.st = st; r.str = str; r.flg = flg;
        r.asel = asel; r.psel = psel; r.wsel = wsel; r.ab = ab; r.ic = ic;
        return r;
    endfunction

    function automatic int kind_of(logic [6:0] op);
        for (int i = 0; i < 9; i++) if (kinds[i].op == op) return i;
        return -1;
    endfunction

    // Model: each instruction is a list of phases still to visit; FETCH/MEM repeat while not ready.
    task automatic model_reset();
        m_plan = '{0, 1};
        m_wait = 0;
        m_ill  = 1'b0;
        m_bus  = 1'b0;
        m_ret  = 0;
        m_kind = 0;
    endtask

    function automatic rec_t model_exp(logic rst, logic [6:0] op, logic bc, logic mr);
        rec_t  e;
        kind_t k;
        k = kinds[m_kind];
        e = mk(rst, op, bc, mr, 3'(m_plan[0]), 6'b0, {m_ill, m_bus}, 1'b0, 2'd0, 2'd0, k.ab, m_ret);
        if (rst) begin
            case (m_plan[0])
                0: e.str = mr ? 6'b101000 : 6'b100000;
                2: if (k.path == 0) begin
                    e.str  = 6'b000101;
                    e.psel = bc ? 2'd2 : 2'd0;
                end
                3: begin
                    e.asel = 1'b1;
                    if (k.path == 1) e.str = mr ? 6'b110101 : 6'b110000;
                    else             e.str = 6'b100000;
                end
                4: begin
                    e.str  = 6'b000111;
                    e.wsel = k.wsel;
                    e.psel = k.psel;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic model_advance(input logic rst, input logic [6:0] op, input logic mr, input logic ret);
        int ph;
        int k;
        if (!rst) begin
            model_reset();
            return;
        end
        if (ret) m_ret++;
        ph = m_plan[0];
        if (ph == 5) return;
        if ((ph == 0 || ph == 3) && !mr) begin
            m_wait++;
            if (WAIT_LIMIT > 0 && m_wait == WAIT_LIMIT) begin
                m_bus  = 1'b1;
                m_plan = '{5};
            end
            return;
        end
        m_wait = 0;
        void'(m_plan.pop_front());
        if (ph == 1) begin
            k = kind_of(op);
            if (k < 0) begin
                m_ill  = 1'b1;
                m_plan = '{5};
            end else begin
                m_kind = k;
                case (kinds[k].path)
                    0:       m_plan = '{2};
                    1:       m_plan = '{2, 3};
                    2:       m_plan = '{2, 3, 4};
                    default: m_plan = '{2, 4};
                endcase
            end
        end else if (m_plan.size() == 0) begin
            m_plan = '{0, 1};
        end
    endtask

    task automatic mstep(input logic r, input logic [6:0] op, input logic bc, input logic mr, input string tag);
        rec_t e;
        reset = r; opcode = op; branch_cond = bc; mem_ready = mr;
        #2;
        e = model_exp(r, op, bc, mr);
        check_rec(tag, e);
        @(posedge clk);
        #1;
        model_advance(r, op, mr, e.str[0] & r);
    endtask

    task automatic hard_reset();
        reset = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0; opcode = 7'h13; branch_cond = 1'b0; mem_ready = 1'b0; cur_op = 7'h13;
        kinds[0] = '{7'b0110011, 3, 2'b00, 2'd1, 2'd0};
        kinds[1] = '{7'b0010011, 3, 2'b01, 2'd1, 2'd0};
        kinds[2] = '{7'b0000011, 2, 2'b01, 2'd3, 2'd0};
        kinds[3] = '{7'b0100011, 1, 2'b01, 2'd1, 2'd0};
        kinds[4] = '{7'b1100011, 0, 2'b00, 2'd1, 2'd0};
        kinds[5] = '{7'b1101111, 3, 2'b11, 2'd2, 2'd1};
        kinds[6] = '{7'b1100111, 3, 2'b01, 2'd2, 2'd1};
        kinds[7] = '{7'b0110111, 3, 2'b01, 2'd0, 2'd0};
        kinds[8] = '{7'b0010111, 3, 2'b11, 2'd1, 2'd0};

        // ADDI, all-ready
        tbl.push_back(mk(1, 7'h13, 0, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 7'h13, 0, 1, 1, 6'b000000, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 7'h13, 0, 1, 2, 6'b000000, 2'b00, 0, 0, 0, 2'b01, 0));
        tbl.push_back(mk(1, 7'h13, 0, 1, 4, 6'b000111, 2'b00, 0, 0, 1, 2'b01, 0));
        // BEQ taken
        tbl.push_back(mk(1, 7'h63, 1, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 1));
        tbl.push_back(mk(1, 7'h63, 1, 1, 1, 6'b000000, 2'b00, 0, 0, 0, 2'b00, 1));
        tbl.push_back(mk(1, 7'h63, 1, 1, 2, 6'b000101, 2'b00, 0, 2, 0, 2'b00, 1));
        // Load with three wait cycles in MEM
        tbl.push_back(mk(1, 7'h03, 0, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 2));
        tbl.push_back(mk(1, 7'h03, 0, 1, 1, 6'b000000, 2'b00, 0, 0, 0, 2'b00, 2));
        tbl.push_back(mk(1, 7'h03, 0, 1, 2, 6'b000000, 2'b00, 0, 0, 0, 2'b01, 2));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 7'h03, 0, 0, 3, 6'b100000, 2'b00, 1, 0, 0, 2'b01, 2));
        tbl.push_back(mk(1, 7'h03, 0, 1, 3, 6'b100000, 2'b00, 1, 0, 0, 2'b01, 2));
        tbl.push_back(mk(1, 7'h03, 0, 1, 4, 6'b000111, 2'b00, 0, 0, 3, 2'b01, 2));
        // Store interrupted by reset in MEM, then a clean store
        tbl.push_back(mk(1, 7'h23, 0, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 3));
        tbl.push_back(mk(1, 7'h23, 0, 1, 1, 6'b000000, 2'b00, 0, 0, 0, 2'b00, 3));
        tbl.push_back(mk(1, 7'h23, 0, 1, 2, 6'b000000, 2'b00, 0, 0, 0, 2'b01, 3));
        tbl.push_back(mk(0, 7'h23, 0, 1, 3, 6'b000000, 2'b00, 0, 0, 0, 2'b01, 3));
        tbl.push_back(mk(1, 7'h23, 0, 0, 0, 6'b100000, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 7'h23, 0, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 7'h23, 0, 1, 1, 6'b000000, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 7'h23, 0, 1, 2, 6'b000000, 2'b00, 0, 0, 0, 2'b01, 0));
        tbl.push_back(mk(1, 7'h23, 0, 1, 3, 6'b110101, 2'b00, 1, 0, 0, 2'b01, 0));
        // Illegal opcode traps and holds until reset
        tbl.push_back(mk(1, 7'h00, 0, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 1));
        tbl.push_back(mk(1, 7'h00, 0, 1, 1, 6'b000000, 2'b00, 0, 0, 0, 2'b00, 1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 7'h00, 0, 1, 5, 6'b000000, 2'b10, 0, 0, 0, 2'b00, 1));
        tbl.push_back(mk(0, 7'h00, 0, 1, 5, 6'b000000, 2'b10, 0, 0, 0, 2'b00, 1));
        tbl.push_back(mk(1, 7'h00, 0, 1, 0, 6'b101000, 2'b00, 0, 0, 0, 2'b00, 0));

        hard_reset();
        foreach (tbl[i]) begin
            reset = tbl[i].rst; opcode = tbl[i].op; branch_cond = tbl[i].bc; mem_ready = tbl[i].mr;
            #2;
            check_rec($sformatf("vec%0d", i), tbl[i]);
            @(posedge clk);
            #1;
        end

        // FETCH starvation: bus error after WAIT_LIMIT idle cycles, retired count kept
        hard_reset();
        for (int i = 0; i < 4; i++) mstep(1'b1, 7'h13, 1'b0, 1'b1, "addi");
        for (int i = 0; i < 4; i++) mstep(1'b1, 7'h13, 1'b0, 1'b0, "fwait");
        mstep(1'b1, 7'h13, 1'b0, 1'b1, "ftrap");
        chk("fetch timeout state", 32'(state), 32'd5);
        chk("fetch timeout bus_err", 32'(bus_err), 32'd1);
        chk("fetch timeout instret", 32'(instret), INSTRET_EN ? 32'd1 : 32'd0);

        // Ready on the last allowed cycle wins; MEM starvation traps
        hard_reset();
        for (int i = 0; i < 3; i++) mstep(1'b1, 7'h03, 1'b0, 1'b0, "lwait");
        mstep(1'b1, 7'h03, 1'b0, 1'b1, "lready");
        chk("late ready state", 32'(state), 32'd1);
        mstep(1'b1, 7'h03, 1'b0, 1'b1, "ldec");
        mstep(1'b1, 7'h03, 1'b0, 1'b1, "lexec");
        for (int i = 0; i < 4; i++) mstep(1'b1, 7'h03, 1'b0, 1'b0, "mwait");
        chk("mem timeout state", 32'(state), 32'd5);
        chk("mem timeout bus_err", 32'(bus_err), 32'd1);

        // JAL then BEQ not-taken
        hard_reset();
        for (int i = 0; i < 4; i++) mstep(1'b1, 7'h6F, 1'b0, 1'b1, "jal");
        for (int i = 0; i < 3; i++) mstep(1'b1, 7'h63, 1'b0, 1'b1, "bne");

        hard_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_plan[0] == 0)
                cur_op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : kinds[$urandom_range(0, 8)].op;
            mstep(($urandom_range(0, 59) != 0), cur_op, 1'($urandom),
                  ($urandom_range(0, 3) != 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter COUNT_W, default 32, width of retired-instruction counter instret.
REQ-002 Parameter WAIT_LIMIT, default 0; max cycles waiting on mem_ready per access; 0 = unlimited.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset=0 at a rising edge resets the block.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register.
REQ-006 branch_cond  input  1  branch comparison result from the datapath, valid in EXEC.
REQ-007 mem_ready  input  1  memory completes the current access in this cycle.
REQ-008 mem_req / mem_we  output  1 each  memory access request / write enable.
REQ-009 addr_sel  output  1  memory address: 0=PC, 1=ALU result.
REQ-010 ir_write / pc_write / reg_write  output  1 each  IR, PC, register-file write strobes.
REQ-011 pc_sel  output  2  next PC: 0=pc+4, 1=ALU result, 2=branch target.
REQ-012 alu_src_a  output  1 (0=rs1, 1=PC); alu_src_b  output  1 (0=rs2, 1=imm).
REQ-013 wb_sel  output  2  write-back: 0=imm, 1=ALU, 2=pc+4, 3=memory data.
REQ-014 state  output  3; retire  output  1 pulse; illegal, bus_err  output  1 each, sticky; instret  output  COUNT_W.

Function
REQ-015 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 unreachable, map to TRAP.
REQ-016 All strobes (mem_req, mem_we, ir_write, pc_write, reg_write, retire) are combinational from state/inputs and forced 0 during any cycle with reset=0.
REQ-017 FETCH: mem_req=1, addr_sel=0; on mem_ready: ir_write=1, next DECODE; else stay.
REQ-018 DECODE: one cycle; opcode in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} -> EXEC, else -> TRAP with illegal set.
REQ-019 EXEC alu sources: R-type/branch a=0 b=0; I-type/load/store/JALR a=0 b=1; JAL/AUIPC a=1 b=1; LUI a=0 b=1; sources held through MEM and WB.
REQ-020 EXEC branch: pc_write=1, pc_sel=2 if branch_cond else 0, retire=1, next FETCH (3-cycle instruction).
REQ-021 EXEC load/store -> MEM; all other legal opcodes -> WB.
REQ-022 MEM: mem_req=1, addr_sel=1, mem_we=1 for store only; wait for mem_ready; store then pc_write=1, pc_sel=0, retire=1 -> FETCH; load -> WB.
REQ-023 WB: reg_write=1, pc_write=1, retire=1 -> FETCH; wb_sel: LUI 0, load 3, JAL/JALR 2, else 1; pc_sel 1 for JAL/JALR, else 0.
REQ-024 mem_req, addr_sel, mem_we stay stable while mem_ready is low.
REQ-025 WAIT_LIMIT>0: wait counter clears on entry to FETCH/MEM; WAIT_LIMIT consecutive cycles with mem_ready=0 -> TRAP with bus_err set; mem_ready in that last cycle wins.
REQ-026 TRAP: all strobes 0, stays until reset; illegal/bus_err hold.
REQ-027 retire asserts exactly one cycle per completed instruction; instret increments by 1 per retire and wraps modulo 2^COUNT_W.

Reset
REQ-028 reset=0 at a clock edge: state=FETCH, illegal=0, bus_err=0, instret=0, wait counter=0, any pending access abandoned.
REQ-029 First cycle after reset release shows FETCH with mem_req=1, addr_sel=0.

Configuration
REQ-030 Macro MCSEQ_INSTRET_EN defined: instret counter implemented per REQ-027.
REQ-031 MCSEQ_INSTRET_EN undefined: no counter flops; instret tied to 0; retire still pulses.

Verification
REQ-032 ADDI (0010011), mem_ready always 1 -> states 0,1,2,4,0; reg_write=1, wb_sel=1 in WB; instret 0->1.
REQ-033 Load, mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, addr_sel=1, mem_we=0; then WB wb_sel=3.
REQ-034 BEQ (1100011), branch_cond=1 -> EXEC pc_write=1, pc_sel=2, reg_write never 1; retire on cycle 3.
REQ-035 opcode 7'h00 -> TRAP after DECODE, illegal=1, no mem_req for 10 cycles; reset pulse -> FETCH, illegal=0.
REQ-036 WAIT_LIMIT=4, mem_ready held 0 in FETCH -> TRAP after 4 waiting cycles, bus_err=1, instret unchanged.
REQ-037 reset=0 during store MEM cycle -> mem_we=0 that cycle; after release state=0, instret=0.
